vram_scanout: RTL and testbench

Text-mode video scanout engine on the read side of the dual-clock video RAM. Runs on the read clock (one pixel per clock). It generates raster timing, fetches character codes from the VRAM read port and looks up glyph rows in an external character ROM. It then shifts out serial pixels with hsync/vsync/data-enable aligned to them. Output feeds the video DAC/encoder stage.

---
 rtl/vram_video_pkg.sv | 31 +++
 rtl/vram_scanout_if.sv | 24 ++
 rtl/vram_scanout_video_timing.sv | 62 ++++++
 rtl/vram_scanout.sv | 122 ++++++++++++
 tb/tb_vram_scanout.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vram_video_pkg.sv
// Default raster geometry, glyph dimensions and shared types for the
// text-mode scanout path.
package vram_video_pkg;

    localparam int DEF_COLS         = 40;
    localparam int DEF_ROWS         = 25;
    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_H_TOTAL      = 400;
    localparam int DEF_H_SYNC_START = 336;
    localparam int DEF_H_SYNC_LEN   = 32;
    localparam int DEF_V_TOTAL      = 262;
    localparam int DEF_V_SYNC_START = 224;
    localparam int DEF_V_SYNC_LEN   = 3;
    localparam int GLYPH_W          = 8;
    localparam int GLYPH_H          = 8;

    typedef struct packed {
        logic de;
        logic hsync_n;
        logic vsync_n;
    } vid_ctl_t;

    localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

    function automatic logic in_window(input logic [31:0] pos,
                                       input logic [31:0] start,
                                       input logic [31:0] len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// Memory-side and video-side signals of the scanout engine.
interface vram_scanout_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] vram_addr;
    logic [7:0]            vram_q;
    logic [9:0]            crom_addr;
    logic [7:0]            crom_q;
    logic                  pixel;
    logic                  de;
    logic                  hsync_n;
    logic                  vsync_n;
    logic                  frame_start;

    modport master (
        output vram_addr, crom_addr, pixel, de, hsync_n, vsync_n, frame_start,
        input  vram_q, crom_q
    );

    modport slave (
        input  vram_addr, crom_addr, pixel, de, hsync_n, vsync_n, frame_start,
        output vram_q, crom_q
    );
endinterface

// File: rtl/vram_scanout_video_timing.sv
// Raster counters with undelayed visible/sync decodes and the frame marker.
module video_timing
    import vram_video_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
    localparam int HW          = $clog2(H_TOTAL),
    localparam int VW          = $clog2(V_TOTAL)
)(
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output logic          o_visible,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_line_end,
    output logic          o_frame_end,
    output logic          o_frame_start
);
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_frame_start;
    logic          w_line_end;
    logic          w_frame_end;

    assign w_line_end  = (r_hcnt == HW'(H_TOTAL - 1));
    assign w_frame_end = w_line_end && (r_vcnt == VW'(V_TOTAL - 1));

    // Raster position; frame_start is decoded from the wrap so it is high while the counters sit at (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt        <= {HW{1'b0}};
            r_vcnt        <= {VW{1'b0}};
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_end;
            if (w_line_end) begin
                r_hcnt <= {HW{1'b0}};
                r_vcnt <= w_frame_end ? {VW{1'b0}} : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
                r_vcnt <= r_vcnt;
            end
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_visible     = (32'(r_hcnt) < 32'(COLS * GLYPH_W)) && (32'(r_vcnt) < 32'(ROWS * GLYPH_H));
    assign o_hsync       = in_window(32'(r_hcnt), 32'(H_SYNC_START), 32'(H_SYNC_LEN));
    assign o_vsync       = in_window(32'(r_vcnt), 32'(V_SYNC_START), 32'(V_SYNC_LEN));
    assign o_line_end    = w_line_end;
    assign o_frame_end   = w_frame_end;
    assign o_frame_start = r_frame_start;
endmodule

// File: rtl/vram_scanout.sv
// Text-mode scanout: character fetch, glyph-row lookup and serial pixel output,
// with de/hsync/vsync delayed three clocks to line up with the pixel stream.
module vram_scanout
    import vram_video_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
    parameter int INVERT_BIT7  = 1
)(
    input  logic           clk,
    input  logic           reset,
    vram_scanout_if.master bus
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0]         w_hcnt;
    logic [VW-1:0]         w_vcnt;
    logic                  w_visible, w_vvisible, w_hsync, w_vsync;
    logic                  w_line_end, w_frame_end, w_frame_start, w_fetch;
    logic [ADDR_WIDTH-1:0] r_row_base, r_vram_addr;
    logic                  r_fetch1, r_fetch2, r_inv, r_pixel;
    logic [9:0]            r_crom_addr;
    logic [7:0]            r_shreg, w_shreg_next;
    vid_ctl_t              w_ctl, r_ctl_d1, r_ctl_d2, r_ctl_d3;

    video_timing #(
        .COLS(COLS), .ROWS(ROWS), .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START),
        .H_SYNC_LEN(H_SYNC_LEN), .V_TOTAL(V_TOTAL), .V_SYNC_START(V_SYNC_START),
        .V_SYNC_LEN(V_SYNC_LEN)
    ) u_timing (
        .clk(clk), .reset(reset), .o_hcnt(w_hcnt), .o_vcnt(w_vcnt),
        .o_visible(w_visible), .o_hsync(w_hsync), .o_vsync(w_vsync),
        .o_line_end(w_line_end), .o_frame_end(w_frame_end), .o_frame_start(w_frame_start)
    );

    assign w_vvisible = (32'(w_vcnt) < 32'(ROWS * GLYPH_H));
    assign w_fetch    = w_visible && (w_hcnt[2:0] == 3'd0);

    // Character-row base address, stepped by COLS instead of multiplying crow by COLS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_base <= {ADDR_WIDTH{1'b0}};
        end else if (w_frame_end) begin
            r_row_base <= {ADDR_WIDTH{1'b0}};
        end else if (w_line_end && w_vvisible && (w_vcnt[2:0] == 3'd7)) begin
            r_row_base <= r_row_base + ADDR_WIDTH'(COLS);
        end else begin
            r_row_base <= r_row_base;
        end
    end

    // F0 issues the VRAM address, F1 turns the code into a glyph-row address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vram_addr <= {ADDR_WIDTH{1'b0}};
            r_crom_addr <= 10'd0;
            r_inv       <= 1'b0;
            r_fetch1    <= 1'b0;
            r_fetch2    <= 1'b0;
        end else begin
            r_fetch1    <= w_fetch;
            r_fetch2    <= r_fetch1;
            r_vram_addr <= w_fetch ? r_row_base + ADDR_WIDTH'(w_hcnt >> 3) : r_vram_addr;
            r_crom_addr <= r_fetch1 ? {bus.vram_q[6:0], w_vcnt[2:0]} : r_crom_addr;
            r_inv       <= r_fetch1 ? ((INVERT_BIT7 != 0) & bus.vram_q[7]) : r_inv;
        end
    end

    // Next shifter state: load a glyph row at F2, shift while visible, otherwise blank
    always_comb begin
        w_shreg_next = 8'h00;
        if (r_fetch2) begin
            w_shreg_next = bus.crom_q ^ {8{r_inv}};
        end else if (r_ctl_d2.de) begin
            w_shreg_next = {r_shreg[6:0], 1'b0};
        end else begin
            w_shreg_next = 8'h00;
        end
    end

    // Shifter plus a pixel register equal to the shifter MSB gated by the aligned de
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= 8'h00;
            r_pixel <= 1'b0;
        end else begin
            r_shreg <= w_shreg_next;
            r_pixel <= w_shreg_next[7] & r_ctl_d2.de;
        end
    end

    assign w_ctl = '{de: w_visible, hsync_n: ~w_hsync, vsync_n: ~w_vsync};

    // Three-stage delay so de and the syncs match the fetch latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctl_d1 <= CTL_IDLE;
            r_ctl_d2 <= CTL_IDLE;
            r_ctl_d3 <= CTL_IDLE;
        end else begin
            r_ctl_d1 <= w_ctl;
            r_ctl_d2 <= r_ctl_d1;
            r_ctl_d3 <= r_ctl_d2;
        end
    end

    assign bus.vram_addr   = r_vram_addr;
    assign bus.crom_addr   = r_crom_addr;
    assign bus.pixel       = r_pixel;
    assign bus.de          = r_ctl_d3.de;
    assign bus.hsync_n     = r_ctl_d3.hsync_n;
    assign bus.vsync_n     = r_ctl_d3.vsync_n;
    assign bus.frame_start = w_frame_start;
endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout on a reduced 4x3-character raster.
module tb_vram_scanout;
    localparam int COLS = 4, ROWS = 3, AW = 4;
    localparam int HT = 48, HSS = 38, HSL = 4;
    localparam int VT = 30, VSS = 26, VSL = 2;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vram_scanout_if #(.ADDR_WIDTH(AW)) bus ();

    logic [7:0] vmem [0:15];
    logic [7:0] rom  [0:1023];

    assign bus.vram_q = vmem[bus.vram_addr];
    assign bus.crom_q = rom[bus.crom_addr];

    vram_scanout #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .H_TOTAL(HT), .H_SYNC_START(HSS),
        .H_SYNC_LEN(HSL), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .INVERT_BIT7(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] outs;
        int         h;
        int         v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   hr, vr, exp_addr, fs_cnt, hs_pulses, hs_w, vs_w;
    bit   first, fs_seen;
    logic prev_hs, prev_vs;
    logic [7:0] cap0, cap10;

    // Expected {pixel, de, hsync_n, vsync_n} for raster position (h, v)
    function automatic logic [3:0] model(input int h, input int v);
        logic [7:0] code, g;
        logic       de_e, px;
        de_e = (h < COLS * 8) && (v < ROWS * 8);
        px   = 1'b0;
        if (de_e) begin
            code = vmem[(v / 8) * COLS + h / 8];
            g    = rom[{code[6:0], 3'(v % 8)}];
            if (code[7]) g = ~g;
            px = g[7 - (h % 8)];
        end
        return {px, de_e, !(h >= HSS && h < HSS + HSL), !(v >= VSS && v < VSS + VSL)};
    endfunction

    task automatic reset_model();
        exp_t idle;
        idle.outs = 4'b0011; idle.h = -1; idle.v = -1;
        sb.delete();
        repeat (3) sb.push_back(idle);
        hr = 0; vr = 0; exp_addr = 0; first = 1'b1; fs_seen = 1'b0;
        fs_cnt = 0; hs_pulses = 0; hs_w = 0; vs_w = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; cap0 = 8'hxx; cap10 = 8'hxx;
    endtask

    task automatic step();
        exp_t       e, o;
        logic       fs_exp;
        logic [3:0] got;
        @(negedge clk);
        e.outs = model(hr, vr); e.h = hr; e.v = vr;
        sb.push_back(e);
        o   = sb.pop_front();
        got = {bus.pixel, bus.de, bus.hsync_n, bus.vsync_n};
        checks++;
        assert (got === o.outs) else begin
            failures++;
            $error("FAIL outs h=%0d v=%0d got=%b exp=%b", o.h, o.v, got, o.outs);
        end
        fs_exp = (hr == 0) && (vr == 0) && !first;
        checks++;
        assert (bus.frame_start === fs_exp) else begin
            failures++;
            $error("FAIL frame_start h=%0d v=%0d got=%b exp=%b", hr, vr, bus.frame_start, fs_exp);
        end
        checks++;
        assert (bus.vram_addr === AW'(exp_addr)) else begin
            failures++;
            $error("FAIL vram_addr h=%0d v=%0d got=%0d exp=%0d", hr, vr, bus.vram_addr, exp_addr);
        end
        if (o.v == 0 && o.h >= 0 && o.h < 8) cap0[7 - o.h] = bus.pixel;
        if (o.v == 10 && o.h >= 8 && o.h < 16) cap10[15 - o.h] = bus.pixel;
        // sync pulse widths and per-frame counts
        if (prev_hs && !bus.hsync_n) hs_pulses++;
        if (!bus.hsync_n) hs_w++;
        else if (!prev_hs) begin
            checks++;
            assert (hs_w == HSL) else begin
                failures++;
                $error("FAIL hsync_width got=%0d exp=%0d", hs_w, HSL);
            end
            hs_w = 0;
        end
        if (!bus.vsync_n) vs_w++;
        else if (!prev_vs) begin
            checks++;
            assert (vs_w == VSL * HT) else begin
                failures++;
                $error("FAIL vsync_width got=%0d exp=%0d", vs_w, VSL * HT);
            end
            vs_w = 0;
        end
        fs_cnt++;
        if (bus.frame_start === 1'b1) begin
            if (fs_seen) begin
                checks++;
                assert (fs_cnt == FRAME) else begin
                    failures++;
                    $error("FAIL frame_period got=%0d exp=%0d", fs_cnt, FRAME);
                end
                checks++;
                assert (hs_pulses == VT) else begin
                    failures++;
                    $error("FAIL hsync_per_frame got=%0d exp=%0d", hs_pulses, VT);
                end
            end
            fs_seen = 1'b1; fs_cnt = 0; hs_pulses = 0;
        end
        prev_hs = bus.hsync_n;
        prev_vs = bus.vsync_n;
        if (hr < COLS * 8 && vr < ROWS * 8 && hr % 8 == 0) exp_addr = (vr / 8) * COLS + hr / 8;
        first = 1'b0;
        if (hr == HT - 1) begin
            hr = 0;
            vr = (vr == VT - 1) ? 0 : vr + 1;
        end else begin
            hr++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        logic [4:0] outs;
        outs = {bus.pixel, bus.de, bus.hsync_n, bus.vsync_n, bus.frame_start};
        checks++;
        assert (outs === 5'b00110) else begin
            failures++;
            $error("FAIL %s_outs got=%b exp=00110", tag, outs);
        end
        checks++;
        assert ({bus.vram_addr, bus.crom_addr} === 14'd0) else begin
            failures++;
            $error("FAIL %s_addrs got=%h/%h exp=0/0", tag, bus.vram_addr, bus.crom_addr);
        end
    endtask

    task automatic check_glyphs(input string tag);
        checks++;
        assert (cap0 === 8'hA5) else begin
            failures++;
            $error("FAIL %s_line0_glyph got=%b exp=10100101", tag, cap0);
        end
        checks++;
        assert (cap10 === 8'h5A) else begin
            failures++;
            $error("FAIL %s_row10_inverse got=%b exp=01011010", tag, cap10);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vmem[i] = 8'(i * 29 + 3);
        vmem[0] = 8'h01;
        vmem[COLS + 1] = 8'h81;
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 37 + 11);
        rom[{7'd1, 3'd0}] = 8'hA5;
        rom[{7'd1, 3'd2}] = 8'hA5;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");

        @(posedge clk);
        reset_model();
        #1 reset = 1'b0;
        repeat (2 * FRAME + 10) step();
        check_glyphs("run1");

        for (int i = 0; i < FRAME; i++) begin
            if (hr == 20 && vr == 12) break;
            step();
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("midframe");
        repeat (2) @(posedge clk);
        reset_model();
        #1 reset = 1'b0;
        repeat (2 * FRAME + 10) step();
        check_glyphs("run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
